// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake and result bus between the result register and the
// binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     lz_mask;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, lz_mask, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, lz_mask, overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with overflow saturation and a leading-zero mask for display blanking.

// One BCD digit of the add-3 correction stage.
module bcd_add3_cell (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? 4'(d + 4'd3) : d;
endmodule

module bin_to_bcd_seq #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  bin_to_bcd_seq_if.slave bus
);
  // Scratch always carries at least one digit above DIGITS so any value that
  // does not fit shows up as a nonzero upper digit.
  localparam int NEED = (BIN_W + 2) / 3;
  localparam int SDIG = ((NEED > DIGITS) ? NEED : DIGITS) + 1;
  localparam int SW   = 4 * SDIG;
  localparam int OW   = 4 * DIGITS;
  localparam int CW   = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic [SW-1:0]     scr;
  logic [SW-1:0]     scr_adj;
  logic [SW-1:0]     scr_nxt;
  logic [BIN_W-1:0]  bin_sr;
  logic [CW-1:0]     cnt;

  logic              busy_q;
  logic              done_q;
  logic [OW-1:0]     bcd_q;
  logic [DIGITS-1:0] lz_q;
  logic              ovf_q;

  logic              ovf_nxt;
  logic [OW-1:0]     bcd_nxt;
  logic [DIGITS-1:0] lz_nxt;

  genvar g;
  generate
    for (g = 0; g < SDIG; g++) begin : g_dig
      bcd_add3_cell u_cell (
        .d(scr[4*g +: 4]),
        .q(scr_adj[4*g +: 4])
      );
    end
  endgenerate

  assign scr_nxt = {scr_adj[SW-2:0], bin_sr[BIN_W-1]};

  // Results are taken from the scratch value produced by the final step.
  assign ovf_nxt = |scr_nxt[SW-1:OW];
  assign bcd_nxt = ovf_nxt ? {DIGITS{4'h9}} : scr_nxt[OW-1:0];

  assign lz_nxt[0] = 1'b0;
  generate
    for (g = 1; g < DIGITS; g++) begin : g_lz
      assign lz_nxt[g] = ~|bcd_nxt[OW-1:4*g];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      scr    <= '0;
      bin_sr <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q  <= '0;
      lz_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            bin_sr <= bus.bin_in;
            scr    <= '0;
            cnt    <= CW'(BIN_W);
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          scr    <= scr_nxt;
          bin_sr <= bin_sr << 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            bcd_q  <= bcd_nxt;
            lz_q   <= lz_nxt;
            ovf_q  <= ovf_nxt;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.lz_mask  = lz_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboarded bench for bin_to_bcd_seq: a 12-bit instance for timing, handshake
// and random checks, and a 14-bit instance for overflow saturation.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(12), .DIGITS(4)) ia ();
  bin_to_bcd_seq_if #(.BIN_W(14), .DIGITS(4)) ib ();

  bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  lz;
    logic        ovf;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   n_done = 0;
  int   cyc = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Independent reference: decimal digits by division, leading zero iff v < 10^k.
  function automatic exp_t model(input int v);
    exp_t e;
    int   p;
    e = '0;
    if (v > 9999) begin
      e.bcd = 16'h9999;
      e.ovf = 1'b1;
    end else begin
      p = 1;
      for (int k = 0; k < 4; k++) begin
        e.bcd[4*k +: 4] = 4'((v / p) % 10);
        e.lz[k] = (k > 0) && (v < p);
        p = p * 10;
      end
    end
    return e;
  endfunction

  // Scoreboard consumer for the 12-bit instance.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && ia.done) begin
      n_done++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done got bcd=%h required no done pulse", ia.bcd_out);
      end else begin
        e = sb.pop_front();
        if ({ia.bcd_out, ia.lz_mask, ia.overflow} !== e) begin
          bad++;
          $display("FAIL sb_result got bcd=%h lz=%b ovf=%b required bcd=%h lz=%b ovf=%b",
                   ia.bcd_out, ia.lz_mask, ia.overflow, e.bcd, e.lz, e.ovf);
        end
      end
    end
  end

  // Drives start for one cycle; on return the accepting edge T0 has passed (k=1).
  task automatic start_conv(input int v);
    @(negedge clk);
    ia.start  = 1'b1;
    ia.bin_in = 12'(v);
    sb.push_back(model(v));
    @(negedge clk);
    ia.start  = 1'b0;
    ia.bin_in = 12'($urandom);
  endtask

  task automatic convert(input int v);
    exp_t e;
    e = model(v);
    start_conv(v);
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk);
      total++;
      if (ia.busy !== (k <= 12) || ia.done !== (k == 13)) begin
        bad++;
        $display("FAIL timing v=%0d k=%0d got busy=%b done=%b required busy=%b done=%b",
                 v, k, ia.busy, ia.done, (k <= 12), (k == 13));
      end
    end
    @(negedge clk);
    total++;
    if (ia.bcd_out !== e.bcd || ia.lz_mask !== e.lz || ia.overflow !== e.ovf) begin
      bad++;
      $display("FAIL held v=%0d got bcd=%h lz=%b required bcd=%h lz=%b",
               v, ia.bcd_out, ia.lz_mask, e.bcd, e.lz);
    end
  endtask

  task automatic test_reset;
    ia.start = 1'b0; ia.bin_in = '0;
    ib.start = 1'b0; ib.bin_in = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ia.busy, ia.done, ia.bcd_out, ia.lz_mask, ia.overflow} !== '0 ||
        {ib.busy, ib.done, ib.bcd_out, ib.lz_mask, ib.overflow} !== '0) begin
      bad++;
      $display("FAIL reset_state got a=%h b=%h required 0",
               {ia.busy, ia.done, ia.bcd_out, ia.lz_mask, ia.overflow},
               {ib.busy, ib.done, ib.bcd_out, ib.lz_mask, ib.overflow});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int vals[9] = '{0, 255, 4095, 1, 9, 10, 999, 1000, 2048};
    foreach (vals[i]) convert(vals[i]);
  endtask

  task automatic test_ignore_start;
    int n0;
    n0 = n_done;
    start_conv(321);
    for (int k = 2; k <= 14; k++) begin
      @(negedge clk);
      ia.start  = (k == 5) || (k == 13);
      ia.bin_in = (k == 5) ? 12'd777 : 12'(k);
    end
    @(negedge clk);
    ia.start = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (n_done - n0 != 1 || sb.size() != 0 || ia.busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start got dones=%0d pending=%0d busy=%b required 1 0 0",
               n_done - n0, sb.size(), ia.busy);
    end
  endtask

  task automatic test_reset_mid;
    int n0;
    n0 = n_done;
    start_conv(3000);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({ia.busy, ia.done, ia.bcd_out, ia.lz_mask, ia.overflow} !== '0) begin
      bad++;
      $display("FAIL reset_mid got %h required 0",
               {ia.busy, ia.done, ia.bcd_out, ia.lz_mask, ia.overflow});
    end
    sb.delete();
    repeat (20) @(negedge clk);
    total++;
    if (n_done != n0 || ia.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_done got dones=%0d required 0", n_done - n0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    convert(1234);
  endtask

  task automatic wide_conv(input int v);
    exp_t e;
    int   k;
    e = model(v);
    @(negedge clk);
    ib.start  = 1'b1;
    ib.bin_in = 14'(v);
    @(negedge clk);
    ib.start  = 1'b0;
    ib.bin_in = 14'($urandom);
    k = 1;
    while (ib.done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k != 15) begin
      bad++;
      $display("FAIL wide_latency v=%0d got k=%0d required 15", v, k);
    end
    total++;
    if (ib.bcd_out !== e.bcd || ib.lz_mask !== e.lz || ib.overflow !== e.ovf) begin
      bad++;
      $display("FAIL wide_result v=%0d got bcd=%h lz=%b ovf=%b required bcd=%h lz=%b ovf=%b",
               v, ib.bcd_out, ib.lz_mask, ib.overflow, e.bcd, e.lz, e.ovf);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overflow;
    int vals[6] = '{12345, 9999, 10000, 16383, 0, 10};
    foreach (vals[i]) wide_conv(vals[i]);
  endtask

  task automatic test_back_to_back;
    int n0, last, w;
    n0 = n_done;
    last = 0;
    for (int i = 0; i < 5; i++) sb.push_back(model(37));
    @(negedge clk);
    ia.bin_in = 12'd37;
    ia.start  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      w = 0;
      while (ia.done !== 1'b1 && w < 40) begin
        @(negedge clk);
        w++;
      end
      if (w >= 40) begin
        total++; bad++;
        $display("FAIL b2b_timeout pulse=%0d got no done required done", i);
      end else if (i > 0) begin
        total++;
        if (cyc - last != 14) begin
          bad++;
          $display("FAIL b2b_period got %0d required 14", cyc - last);
        end
      end
      last = cyc;
    end
    ia.start = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (n_done - n0 != 5 || sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_count got dones=%0d pending=%0d required 5 0", n_done - n0, sb.size());
    end
  endtask

  task automatic test_random;
    int bnd[4] = '{999, 1000, 1001, 4094};
    foreach (bnd[i]) convert(bnd[i]);
    for (int i = 0; i < 1000; i++) convert(int'($urandom_range(0, 4095)));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_mid();
    test_overflow();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
